// File: rtl/sram_arbiter.sv
// sram_arbiter: shares the slot-0 internal SRAM between the Z80/blink path
// and a background loader port.
//   clk, reset_n           : clock, async active-low reset
//   cpu_a/di/ce_n/oe_n/we_n: blink memory strobes and Z80 write data
//   cpu_do                 : read data back to blink (FF when not reading)
//   ldr_req/we/a/wd        : loader request, held stable until ldr_ack
//   ldr_ack, ldr_rd        : one-cycle completion pulse, last read data
//   ldr_abort_cnt          : saturating count of CPU pre-emptions
//   sram_*                 : external asynchronous SRAM pins
// The CPU has no wait line, so it always owns the bus combinationally.
// A loader access that collides with the CPU is dropped and restarted from
// scratch once the CPU releases chip enable.
module sram_arbiter #(
  parameter int AW      = 19,
  parameter int DW      = 8,
  parameter int ACC_CYC = 3,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [AW-1:0]    cpu_a,
  input  logic [DW-1:0]    cpu_di,
  input  logic             cpu_ce_n,
  input  logic             cpu_oe_n,
  input  logic             cpu_we_n,
  output logic [DW-1:0]    cpu_do,
  input  logic             ldr_req,
  input  logic             ldr_we,
  input  logic [AW-1:0]    ldr_a,
  input  logic [DW-1:0]    ldr_wd,
  output logic             ldr_ack,
  output logic [DW-1:0]    ldr_rd,
  output logic [CNT_W-1:0] ldr_abort_cnt,
  output logic [AW-1:0]    sram_a,
  output logic [DW-1:0]    sram_di,
  input  logic [DW-1:0]    sram_do,
  output logic             sram_ce_n,
  output logic             sram_oe_n,
  output logic             sram_we_n
);

  localparam int CW = (ACC_CYC > 2) ? $clog2(ACC_CYC) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(ACC_CYC - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RETRY  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          lat_we;
  logic [AW-1:0] lat_a;
  logic [DW-1:0] lat_wd;
  // Last driven address/data, so an idle bus does not glitch the pins.
  logic [AW-1:0] hold_a;
  logic [DW-1:0] hold_di;

  logic ldr_drv;
  logic last;

  assign ldr_drv = (state == ACCESS) && cpu_ce_n;
  assign last    = (cnt == '0);

  always_comb begin
    sram_a    = hold_a;
    sram_di   = hold_di;
    sram_ce_n = 1'b1;
    sram_oe_n = 1'b1;
    sram_we_n = 1'b1;
    cpu_do    = '1;
    if (!reset_n) begin
      // Reset gates the pins directly so strobes drop without a clock.
      sram_a  = '0;
      sram_di = '0;
    end else if (!cpu_ce_n) begin
      sram_a    = cpu_a;
      sram_di   = cpu_di;
      sram_ce_n = 1'b0;
      sram_oe_n = cpu_oe_n;
      sram_we_n = cpu_we_n;
      if (!cpu_oe_n) cpu_do = sram_do;
    end else if (ldr_drv) begin
      sram_a    = lat_a;
      sram_di   = lat_wd;
      sram_ce_n = 1'b0;
      sram_oe_n = lat_we;
      // Final write cycle releases WE with address/data still held.
      sram_we_n = !(lat_we && !last);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      lat_we        <= 1'b0;
      lat_a         <= '0;
      lat_wd        <= '0;
      hold_a        <= '0;
      hold_di       <= '0;
      ldr_ack       <= 1'b0;
      ldr_rd        <= '0;
      ldr_abort_cnt <= '0;
    end else begin
      ldr_ack <= 1'b0;
      hold_a  <= sram_a;
      hold_di <= sram_di;
      case (state)
        IDLE: begin
          if (ldr_req) begin
            lat_we <= ldr_we;
            lat_a  <= ldr_a;
            lat_wd <= ldr_wd;
            cnt    <= CNT_LOAD;
            state  <= cpu_ce_n ? ACCESS : RETRY;
          end
        end
        ACCESS: begin
          if (!cpu_ce_n) begin
            state <= RETRY;
            cnt   <= CNT_LOAD;
            if (ldr_abort_cnt != '1) ldr_abort_cnt <= ldr_abort_cnt + 1'b1;
          end else if (last) begin
            if (!lat_we) ldr_rd <= sram_do;
            ldr_ack <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RETRY: begin
          if (cpu_ce_n) state <= ACCESS;
        end
        default: state <= IDLE; // DONE: ack is high this cycle
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural async SRAM model.
module tb_sram_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [18:0] cpu_a;
  logic [7:0]  cpu_di;
  logic        cpu_ce_n, cpu_oe_n, cpu_we_n;
  logic [7:0]  cpu_do;
  logic        ldr_req, ldr_we;
  logic [18:0] ldr_a;
  logic [7:0]  ldr_wd;
  logic        ldr_ack;
  logic [7:0]  ldr_rd;
  logic [7:0]  ldr_abort_cnt;
  logic [18:0] sram_a;
  logic [7:0]  sram_di, sram_do;
  logic        sram_ce_n, sram_oe_n, sram_we_n;

  logic [7:0] mem [0:(1<<19)-1];
  int ntot = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  assign sram_do = mem[sram_a];
  always @(posedge clk)
    if (!sram_ce_n && !sram_we_n) mem[sram_a] <= sram_di;

  sram_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_a(cpu_a), .cpu_di(cpu_di), .cpu_ce_n(cpu_ce_n),
    .cpu_oe_n(cpu_oe_n), .cpu_we_n(cpu_we_n), .cpu_do(cpu_do),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_a(ldr_a), .ldr_wd(ldr_wd),
    .ldr_ack(ldr_ack), .ldr_rd(ldr_rd), .ldr_abort_cnt(ldr_abort_cnt),
    .sram_a(sram_a), .sram_di(sram_di), .sram_do(sram_do),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_idle();
    cpu_ce_n = 1'b1; cpu_oe_n = 1'b1; cpu_we_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    cpu_a = '0; cpu_di = '0;
    cpu_ce_n = 1'b0; cpu_oe_n = 1'b0; cpu_we_n = 1'b0; // must be masked by reset
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_a = '0; ldr_wd = '0;
    #2;
    chk("rst_ce_n", sram_ce_n, 1);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_oe_n", sram_oe_n, 1);
    chk("rst_cpu_do", cpu_do, 8'hFF);
    chk("rst_sram_a", sram_a, 0);
    chk("rst_ack", ldr_ack, 0);
    chk("rst_abort", ldr_abort_cnt, 0);
    chk("rst_rd", ldr_rd, 0);
    cpu_idle();
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Preload through the CPU write path
    cpu_ce_n = 1'b0; cpu_we_n = 1'b0;
    cpu_a = 19'h01234; cpu_di = 8'h5A; tick();
    cpu_a = 19'h00010; cpu_di = 8'h11; tick();
    cpu_a = 19'h00200; cpu_di = 8'h77; tick();
    cpu_we_n = 1'b1; cpu_oe_n = 1'b0; cpu_a = 19'h01234;
    #1;
    chk("cpu_rd_do", cpu_do, 8'h5A);
    chk("cpu_rd_oe", sram_oe_n, 0);
    cpu_idle();
    #1;
    chk("cpu_idle_do", cpu_do, 8'hFF);
    tick();

    // Loader read, CPU idle
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_a = 19'h01234;
    #1 chk("rd_pre_oe", sram_oe_n, 1);
    tick(); chk("rd_c1_oe", sram_oe_n, 0); chk("rd_c1_a", sram_a, 19'h01234);
    tick(); chk("rd_c2_oe", sram_oe_n, 0); chk("rd_c2_ack", ldr_ack, 0);
    tick(); chk("rd_c3_oe", sram_oe_n, 0); chk("rd_c3_we", sram_we_n, 1);
    tick(); chk("rd_ack", ldr_ack, 1); chk("rd_data", ldr_rd, 8'h5A); chk("rd_done_oe", sram_oe_n, 1);
    ldr_req = 1'b0;
    tick(); chk("rd_ack_drop", ldr_ack, 0); chk("rd_hold", ldr_rd, 8'h5A);
    chk("rd_abort", ldr_abort_cnt, 0); chk("idle_hold_a", sram_a, 19'h01234);

    // Loader write, CPU idle
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_a = 19'h7FFFF; ldr_wd = 8'hC3;
    tick(); chk("wr_c1_we", sram_we_n, 0); chk("wr_c1_a", sram_a, 19'h7FFFF); chk("wr_c1_di", sram_di, 8'hC3);
    tick(); chk("wr_c2_we", sram_we_n, 0);
    tick(); chk("wr_c3_we", sram_we_n, 1); chk("wr_c3_ce", sram_ce_n, 0); chk("wr_c3_a", sram_a, 19'h7FFFF);
    tick(); chk("wr_ack", ldr_ack, 1); chk("wr_mem", mem[19'h7FFFF], 8'hC3); chk("wr_rd_kept", ldr_rd, 8'h5A);
    ldr_req = 1'b0;
    tick(); chk("wr_ack_drop", ldr_ack, 0);

    // Pre-emption in the 2nd ACCESS cycle
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_a = 19'h00200;
    tick(); chk("pe_c1_a", sram_a, 19'h00200);
    tick(); chk("pe_c2_oe", sram_oe_n, 0);
    cpu_ce_n = 1'b0; cpu_oe_n = 1'b0; cpu_a = 19'h00010;
    #1 chk("pe_cpu_do", cpu_do, 8'h11); chk("pe_cpu_a", sram_a, 19'h00010);
    tick(); chk("pe_abort", ldr_abort_cnt, 1); chk("pe_cpu_do2", cpu_do, 8'h11);
    cpu_idle();
    #1 chk("pe_retry_oe", sram_oe_n, 1);
    tick(); chk("pe_r1_a", sram_a, 19'h00200); chk("pe_r1_oe", sram_oe_n, 0);
    tick(); chk("pe_r2_ack", ldr_ack, 0);
    tick(); chk("pe_r3_ack", ldr_ack, 0); chk("pe_r3_oe", sram_oe_n, 0);
    tick(); chk("pe_ack", ldr_ack, 1); chk("pe_data", ldr_rd, 8'h77);
    ldr_req = 1'b0;
    tick(); chk("pe_ack_drop", ldr_ack, 0);

    // Request arrives while CPU holds the RAM
    cpu_ce_n = 1'b0; cpu_oe_n = 1'b0; cpu_a = 19'h01234;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_a = 19'h7FFFF;
    tick(); chk("sim_a", sram_a, 19'h01234); chk("sim_do", cpu_do, 8'h5A);
    tick(); chk("sim_a2", sram_a, 19'h01234);
    cpu_idle();
    #1 chk("sim_ret_ce", sram_ce_n, 1); chk("sim_ret_oe", sram_oe_n, 1);
    tick(); chk("sim_acc_a", sram_a, 19'h7FFFF); chk("sim_acc_oe", sram_oe_n, 0);
    tick(); tick();
    tick(); chk("sim_ack", ldr_ack, 1); chk("sim_data", ldr_rd, 8'hC3); chk("sim_abort", ldr_abort_cnt, 1);
    ldr_req = 1'b0;
    tick();

    // Saturation: 300 more pre-emptions on top of the existing 1
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_a = 19'h00010;
    tick();
    for (int i = 0; i < 300; i++) begin
      cpu_ce_n = 1'b0;
      tick();
      cpu_ce_n = 1'b1;
      if (i == 252) chk("sat_254", ldr_abort_cnt, 254);
      if (i == 253) chk("sat_255", ldr_abort_cnt, 255);
      tick();
    end
    chk("sat_final", ldr_abort_cnt, 255);
    tick(); tick();
    tick(); chk("sat_ack", ldr_ack, 1); chk("sat_data", ldr_rd, 8'h11);
    ldr_req = 1'b0;
    tick();

    // Reset mid-write
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_a = 19'h00300; ldr_wd = 8'hAB;
    tick(); chk("rw_we_before", sram_we_n, 0);
    reset_n = 1'b0;
    #1 chk("rw_we_async", sram_we_n, 1); chk("rw_ce_async", sram_ce_n, 1);
    chk("rw_abort", ldr_abort_cnt, 0); chk("rw_a", sram_a, 0);
    ldr_req = 1'b0;
    tick(); chk("rw_no_ack", ldr_ack, 0);
    reset_n = 1'b1;
    tick(); chk("rw_post_we", sram_we_n, 1); chk("rw_post_ce", sram_ce_n, 1);
    chk("rw_post_ack", ldr_ack, 0); chk("rw_post_rd", ldr_rd, 0);
    chk("rw_post_do", cpu_do, 8'hFF); chk("rw_post_a", sram_a, 0);

    // FSM must be in IDLE: a fresh read completes with normal latency
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_a = 19'h01234;
    tick(); chk("post_oe", sram_oe_n, 0);
    tick(); tick();
    tick(); chk("post_ack", ldr_ack, 1); chk("post_data", ldr_rd, 8'h5A);
    ldr_req = 1'b0;
    tick();

    $display("%0d/%0d checks passed", ntot - nfail, ntot);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single slot-0 internal RAM chip between two requesters:
  - the Z80/blink memory path, which has priority and zero latency because the Z80 has no wait line;
  - a loader port used by a debug/snapshot loader for background reads and writes.
- Sits between blink (ma, irce_n, roe_n, wrb_n, Z80 data out) and the external SRAM pins.
- Loader accesses are issued only in cycles where the CPU is not selecting RAM.
- A loader access pre-empted by the CPU is aborted and retried.

Parameters:
AW, 19, address width
DW, 8, data width
ACC_CYC, 3, loader access length in clk cycles (min 2)
CNT_W, 8, width of saturating abort counter

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cpu_a  in  AW  blink memory address
cpu_di  in  DW  Z80 write data
cpu_ce_n  in  1  blink RAM chip enable
cpu_oe_n  in  1  blink read strobe
cpu_we_n  in  1  blink write strobe
cpu_do  out  DW  read data to blink
ldr_req  in  1  loader request (level)
ldr_we  in  1  1=write, 0=read
ldr_a  in  AW  loader address
ldr_wd  in  DW  loader write data
ldr_ack  out  1  one-cycle completion pulse
ldr_rd  out  DW  loader read data, valid from ack onward
ldr_abort_cnt  out  CNT_W  saturating count of pre-empted loader accesses
sram_a  out  AW  SRAM address
sram_di  out  DW  SRAM write data
sram_do  in  DW  SRAM read data
sram_ce_n  out  1  SRAM chip enable
sram_oe_n  out  1  SRAM output enable
sram_we_n  out  1  SRAM write enable

Behaviour:
- reset_n low (asynchronous):
  - FSM goes to IDLE; ldr_ack=0, ldr_rd=0, ldr_abort_cnt=0, latched request cleared.
  - sram_ce_n/oe_n/we_n forced to 1 regardless of CPU inputs; sram_a=0, sram_di=0.
  - cpu_do=8'hFF.
- CPU path (combinational, 0 latency), active when cpu_ce_n=0:
  - sram_a=cpu_a, sram_di=cpu_di, sram_ce_n=0, sram_oe_n=cpu_oe_n, sram_we_n=cpu_we_n.
  - cpu_do=sram_do when cpu_ce_n=0 and cpu_oe_n=0, else 8'hFF.
  - The CPU always wins, even in the same cycle the loader FSM is in ACCESS.
- Loader FSM states: IDLE, ACCESS, RETRY, DONE.
  - IDLE: if ldr_req=1, latch ldr_we/ldr_a/ldr_wd, load cycle counter with ACC_CYC-1, then:
    - go to ACCESS if cpu_ce_n=1;
    - go to RETRY if cpu_ce_n=0.
  - ACCESS:
    - When cpu_ce_n=1: SRAM driven from latched fields, sram_ce_n=0.
    - Read: sram_oe_n=0, sram_we_n=1.
    - Write: sram_oe_n=1; sram_we_n=0 on every ACCESS cycle except the last (counter=0), which gives one cycle of address/data hold.
    - Counter decrements each cycle.
  - ACCESS, cpu_ce_n=0 in any cycle: abort.
    - CPU drives the bus that cycle; go to RETRY.
    - ldr_abort_cnt increments, saturating at all-ones.
    - Counter reloads to ACC_CYC-1.
  - ACCESS, counter=0 and cpu_ce_n=1: for reads, register sram_do into ldr_rd; go to DONE.
  - RETRY: SRAM idle from the loader side. When cpu_ce_n=1, go to ACCESS and restart the full ACC_CYC sequence. Interrupted writes are re-executed in full with the same data.
  - DONE: ldr_ack=1 for exactly one cycle, then IDLE. ldr_rd holds until the next completed read.
- Handshake: the requester keeps fields stable while ldr_req=1 until it sees ldr_ack. It must drop ldr_req, or present a new request, on the edge following ack. A request present in IDLE after DONE is a new access. Minimum loader throughput is one access per ACC_CYC+2 cycles.
- Idle bus: when neither the CPU nor the loader is active, sram strobes are 1, and sram_a/sram_di hold their last driven values.

Test Plan:
- Loader read, CPU idle: preload SRAM[0x01234]=0x5A; ldr_req=1, ldr_we=0, ldr_a=0x01234 -> sram_oe_n=0 for 3 cycles, ack pulses 4 cycles after request, ldr_rd=0x5A, abort_cnt=0.
- Loader write, CPU idle: ldr_we=1, ldr_a=0x7FFFF, ldr_wd=0xC3 -> sram_we_n low for 2 cycles then high for 1 with address stable; SRAM[0x7FFFF]=0xC3; single ack.
- Pre-emption: CPU asserts cpu_ce_n=0 in the 2nd ACCESS cycle for 2 cycles reading 0x00010 (=0x11) -> cpu_do=0x11 with no latency; loader retries with a full 3 ACCESS cycles; abort_cnt=1; ack 7 cycles after request.
- Simultaneous: ldr_req rises while cpu_ce_n=0 -> FSM goes to RETRY, loader never drives SRAM until cpu_ce_n=1, no abort counted.
- Saturation: force 300 pre-emptions with CNT_W=8 -> ldr_abort_cnt stops at 255.
- Reset mid-write: assert reset_n=0 in the 1st ACCESS write cycle -> sram_we_n/ce_n go to 1 asynchronously, no ack; after release with ldr_req=0, FSM is in IDLE and outputs are at reset values.
